// File: rtl/aes_ark_pkg.sv
// Shared definitions for the AES AddRoundKey pipeline lane.
// Optional feature macro: AES_ARK_PARITY_EN (per-lane odd parity carried with the data).
package aes_ark_pkg;

  localparam int BYTE_W     = 8;
  localparam int MAX_LANES  = 16;
  localparam int MAX_STAGES = 4;

  typedef logic [BYTE_W-1:0] aes_byte_t;

  // Odd-parity bit for one byte: set when the byte holds an even number of ones,
  // so that byte plus parity bit always carries an odd count (0x00 -> 1).
  function automatic logic odd_par(aes_byte_t b);
    return ~^b;
  endfunction

endpackage

// File: rtl/aes_ark_stage.sv
// One register stage of the AddRoundKey pipeline: valid flag, data word and,
// when AES_ARK_PARITY_EN is defined, the per-lane parity bits travelling with it.
// The stage loads its upstream neighbour whenever its advance enable is high.
module aes_ark_stage
  import aes_ark_pkg::*;
#(
  parameter int LANES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      adv,
  input  logic                      in_vld,
  input  logic [BYTE_W*LANES-1:0]   in_data,
  output logic                      vld,
  output logic [BYTE_W*LANES-1:0]   data
`ifdef AES_ARK_PARITY_EN
  ,
  input  logic [LANES-1:0]          in_par,
  output logic [LANES-1:0]          par
`endif
);

  // Valid follows upstream on advance, so a stage whose beat leaves while nothing arrives empties itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
    end else if (adv) begin
      vld <= in_vld;
    end
  end

  // Payload only moves when a real beat arrives; a bubble leaves the old word in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (adv && in_vld) begin
      data <= in_data;
    end
  end

`ifdef AES_ARK_PARITY_EN
  // Parity bits ride with the payload under the same load condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= '0;
    end else if (adv && in_vld) begin
      par <= in_par;
    end
  end
`endif

endmodule

// File: rtl/aes_ark_pipe.sv
// Pipelined, back-pressurable AES AddRoundKey lane: m_data = s_data ^ key.
// Holds the round-key register, does the XOR on capture into stage 0 and
// counts completed output handshakes. STAGES register stages sit between
// s_data and m_data, so there is no combinational path from input to output.
// Optional feature macro: AES_ARK_PARITY_EN adds m_parity (odd parity per lane).
module aes_ark_pipe
  import aes_ark_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      key_load,
  input  logic [BYTE_W*LANES-1:0]   key_in,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [BYTE_W*LANES-1:0]   s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [BYTE_W*LANES-1:0]   m_data,
  output logic [CNT_W-1:0]          beat_cnt
`ifdef AES_ARK_PARITY_EN
  ,
  output logic [LANES-1:0]          m_parity
`endif
);

  localparam int DATA_W = BYTE_W * LANES;

  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] xor_data;
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv;
  logic [DATA_W-1:0] data [STAGES];
`ifdef AES_ARK_PARITY_EN
  logic [LANES-1:0]  xor_par;
  logic [LANES-1:0]  par [STAGES];
`endif

  // Round-key register; a beat accepted in the loading cycle still sees the old key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= '0;
    end else if (key_load) begin
      key_q <= key_in;
    end
  end

  assign xor_data = s_data ^ key_q;

`ifdef AES_ARK_PARITY_EN
  // Parity is taken from the XOR result so it describes exactly what leaves on m_data.
  always_comb begin
    xor_par = '0;
    for (int i = 0; i < LANES; i++) begin
      xor_par[i] = odd_par(xor_data[BYTE_W*i +: BYTE_W]);
    end
  end
`endif

  // Advance enables, built from the output end backwards so empty stages collapse bubbles.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = m_ready | ~vld[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = ~vld[k] | adv[k+1];
    end
  end

  assign s_ready = adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              in_vld;
    logic [DATA_W-1:0] in_data;
`ifdef AES_ARK_PARITY_EN
    logic [LANES-1:0]  in_par;
`endif

    if (k == 0) begin : g_first
      assign in_vld  = s_valid;
      assign in_data = xor_data;
`ifdef AES_ARK_PARITY_EN
      assign in_par  = xor_par;
`endif
    end else begin : g_next
      assign in_vld  = vld[k-1];
      assign in_data = data[k-1];
`ifdef AES_ARK_PARITY_EN
      assign in_par  = par[k-1];
`endif
    end

    aes_ark_stage #(
      .LANES (LANES)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv[k]),
      .in_vld  (in_vld),
      .in_data (in_data),
      .vld     (vld[k]),
      .data    (data[k])
`ifdef AES_ARK_PARITY_EN
      ,
      .in_par  (in_par),
      .par     (par[k])
`endif
    );
  end

  assign m_valid = vld[STAGES-1];
  assign m_data  = data[STAGES-1];
`ifdef AES_ARK_PARITY_EN
  assign m_parity = par[STAGES-1];
`endif

  // Output handshake counter, free-running modulo 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (m_valid && m_ready) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_ark_pipe.sv
// Self-checking bench for aes_ark_pipe. Inputs change 1 time unit after the
// rising edge; a negedge observer records accepted inputs (expected outputs
// computed as data ^ key from its own key copy) and observed output beats.
module tb_aes_ark_pipe;

  localparam int LANES  = 16;
  localparam int STAGES = 2;
  localparam int CNT_W  = 8;
  localparam int DW     = 8 * LANES;

  localparam logic [DW-1:0] K_0F = {LANES{8'h0F}};
  localparam logic [DW-1:0] K_AA = {LANES{8'hAA}};
  localparam logic [DW-1:0] D_55 = {LANES{8'h55}};
  localparam logic [DW-1:0] D_FF = {LANES{8'hFF}};

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             key_load = 1'b0;
  logic [DW-1:0]    key_in = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DW-1:0]    s_data = '0;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [DW-1:0]    m_data;
  logic [CNT_W-1:0] beat_cnt;
`ifdef AES_ARK_PARITY_EN
  logic [LANES-1:0] m_parity;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] obs_q [$];
  logic [DW-1:0] key_m = '0;
  int            cnt_m = 0;

  aes_ark_pipe #(
    .LANES  (LANES),
    .STAGES (STAGES),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_load (key_load),
    .key_in   (key_in),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .beat_cnt (beat_cnt)
`ifdef AES_ARK_PARITY_EN
    ,
    .m_parity (m_parity)
`endif
  );

  always #5 clk = ~clk;

  // Observer: inputs are stable across the negedge, so this sees what the next edge will do.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      obs_q.delete();
      key_m = '0;
      cnt_m = 0;
    end else begin
      if (m_valid && m_ready) begin
        obs_q.push_back(m_data);
        cnt_m++;
      end
      if (s_valid && s_ready) exp_q.push_back(s_data ^ key_m);
      if (key_load) key_m = key_in;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW / 32; i++) r = (r << 32) | DW'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drain the pipe with m_ready high until n output beats have been observed.
  task automatic drain(input int n, output bit ok);
    s_valid  = 1'b0;
    key_load = 1'b0;
    m_ready  = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (obs_q.size() >= n) break;
      tick();
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    tests_run++;
    if (m_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_m_valid got %b want 0", m_valid); end
    tests_run++;
    if (m_data !== '0) begin tests_failed++; $display("[TB] FAIL reset_m_data got %h want 0", m_data); end
    tests_run++;
    if (beat_cnt !== '0) begin tests_failed++; $display("[TB] FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
    rst = 1'b0;
    tick();
    tests_run++;
    if (s_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_s_ready got %b want 1", s_ready); end
  endtask

  task automatic test_single_beat();
    key_load = 1'b1;
    key_in   = K_0F;
    tick();
    key_load = 1'b0;
    s_valid  = 1'b1;
    s_data   = '0;
    m_ready  = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (STAGES - 1) @(posedge clk);
    #1;
    tests_run++;
    if (m_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_latency_valid got %b want 1", m_valid); end
    tests_run++;
    if (m_data !== K_0F) begin tests_failed++; $display("[TB] FAIL single_data got %h want %h", m_data, K_0F); end
    tick();
    tests_run++;
    if (beat_cnt !== CNT_W'(1)) begin tests_failed++; $display("[TB] FAIL single_beat_cnt got %0d want 1", beat_cnt); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int drops;
    bit ok;
    drops    = 0;
    key_load = 1'b1;
    key_in   = rand_data();
    tick();
    key_load = 1'b0;
    m_ready  = 1'b1;
    for (int i = 0; i < 32; i++) begin
      s_valid = 1'b1;
      s_data  = rand_data();
      if (s_ready !== 1'b1) drops++;
      tick();
    end
    drain(32, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("[TB] FAIL b2b_timeout got %0d beats want 32", obs_q.size()); end
    tests_run++;
    if (drops != 0) begin tests_failed++; $display("[TB] FAIL b2b_s_ready got %0d low cycles want 0", drops); end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL b2b_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    tests_run++;
    if (beat_cnt !== CNT_W'(cnt_m)) begin tests_failed++; $display("[TB] FAIL b2b_beat_cnt got %0d want %0d", beat_cnt, CNT_W'(cnt_m)); end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    int acc;
    int unstable;
    logic [DW-1:0] held;
    bit ok;
    acc      = 0;
    unstable = 0;
    m_ready  = 1'b0;
    for (int i = 0; i < STAGES + 2; i++) begin
      s_valid = 1'b1;
      s_data  = rand_data();
      if (s_ready === 1'b1) acc++;
      tick();
    end
    tests_run++;
    if (acc != STAGES) begin tests_failed++; $display("[TB] FAIL bp_accepted got %0d want %0d", acc, STAGES); end
    tests_run++;
    if (s_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_s_ready got %b want 0", s_ready); end
    held = m_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (m_data !== held || m_valid !== 1'b1 || s_ready !== 1'b0) unstable++;
    end
    tests_run++;
    if (unstable != 0) begin tests_failed++; $display("[TB] FAIL bp_hold got %0d unstable cycles want 0", unstable); end
    drain(STAGES, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("[TB] FAIL bp_timeout got %0d beats want %0d", obs_q.size(), STAGES); end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin tests_failed++; $display("[TB] FAIL bp_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
      end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_key_same_cycle();
    bit ok;
    key_load = 1'b1;
    key_in   = '0;
    s_valid  = 1'b0;
    m_ready  = 1'b1;
    tick();
    key_in  = K_AA;
    s_valid = 1'b1;
    s_data  = D_55;
    tick();
    key_load = 1'b0;
    tick();
    drain(2, ok);
    tests_run++;
    if (!ok || obs_q.size() != 2) begin
      tests_failed++;
      $display("[TB] FAIL key_count got %0d beats want 2", obs_q.size());
    end else begin
      tests_run++;
      if (obs_q[0] !== D_55) begin tests_failed++; $display("[TB] FAIL key_old got %h want %h", obs_q[0], D_55); end
      tests_run++;
      if (obs_q[1] !== D_FF) begin tests_failed++; $display("[TB] FAIL key_new got %h want %h", obs_q[1], D_FF); end
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_random_wrap();
    int mism;
    bit ok;
    mism = 0;
    for (int c = 0; c < 3000 && cnt_m < 270; c++) begin
      s_valid  = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 3) != 0);
      s_data   = rand_data();
      key_load = ($urandom_range(0, 7) == 0);
      key_in   = rand_data();
      tick();
    end
    drain(exp_q.size(), ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("[TB] FAIL rnd_timeout got %0d beats want %0d", obs_q.size(), exp_q.size()); end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("[TB] FAIL rnd_count got %0d want %0d", obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        if (obs_q[i] !== exp_q[i]) begin
          mism++;
          if (mism <= 4) $display("[TB] FAIL rnd_data[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
        end
      end
      tests_run++;
      if (mism != 0) begin tests_failed++; $display("[TB] FAIL rnd_data_total got %0d bad beats want 0", mism); end
    end
    tests_run++;
    if (cnt_m < (1 << CNT_W)) begin tests_failed++; $display("[TB] FAIL wrap_reached got %0d handshakes want >= %0d", cnt_m, 1 << CNT_W); end
    tests_run++;
    if (beat_cnt !== CNT_W'(cnt_m % (1 << CNT_W))) begin
      tests_failed++;
      $display("[TB] FAIL wrap_beat_cnt got %0d want %0d", beat_cnt, cnt_m % (1 << CNT_W));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset_midflight();
    logic [DW-1:0] probe;
`ifdef AES_ARK_PARITY_EN
    logic [LANES-1:0] exp_par;
`endif
    key_load = 1'b1;
    key_in   = rand_data();
    m_ready  = 1'b0;
    tick();
    key_load = 1'b0;
    s_valid  = 1'b1;
    s_data   = rand_data();
    tick();
    s_data = rand_data();
    tick();
    s_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if (m_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_m_valid got %b want 0", m_valid); end
    tests_run++;
    if (beat_cnt !== '0) begin tests_failed++; $display("[TB] FAIL rstmid_beat_cnt got %0d want 0", beat_cnt); end
    @(posedge clk);
    #1;
    rst     = 1'b0;
    m_ready = 1'b1;
    repeat (3) tick();
    tests_run++;
    if (obs_q.size() != 0 || m_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL rstmid_ghost got %0d beats want 0", obs_q.size());
    end
    probe       = rand_data();
    probe[7:0]  = 8'h00;
    m_ready     = 1'b0;
    s_valid     = 1'b1;
    s_data      = probe;
    tick();
    s_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (m_valid === 1'b1) break;
      tick();
    end
    tests_run++;
    if (m_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rstmid_timeout got m_valid %b want 1", m_valid); end
    tests_run++;
    if (m_data !== probe) begin tests_failed++; $display("[TB] FAIL rstmid_key_cleared got %h want %h", m_data, probe); end
`ifdef AES_ARK_PARITY_EN
    for (int i = 0; i < LANES; i++) exp_par[i] = ((probe >> (8 * i)) & 'hFF) % 2 == 0 ? $countones(probe[8*i +: 8]) % 2 == 0 : $countones(probe[8*i +: 8]) % 2 == 0;
    tests_run++;
    if (m_parity !== exp_par) begin tests_failed++; $display("[TB] FAIL parity got %h want %h", m_parity, exp_par); end
    tests_run++;
    if (m_parity[0] !== 1'b1) begin tests_failed++; $display("[TB] FAIL parity_zero_lane got %b want 1", m_parity[0]); end
`endif
    m_ready = 1'b1;
    repeat (2) tick();
    tests_run++;
    if (beat_cnt !== CNT_W'(1)) begin tests_failed++; $display("[TB] FAIL rstmid_cnt_after got %0d want 1", beat_cnt); end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_back_to_back();
    test_backpressure();
    test_key_same_cycle();
    test_random_wrap();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
